// File: rtl/param_universal_register.sv
// Multi-function WIDTH-bit register: parallel load, logic/arithmetic ops and
// one-bit-per-cycle shift/rotate sequences under a start/busy/done handshake.
module param_universal_register #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] pin,
  input  logic             sin,
  output logic [WIDTH-1:0] pout,
  output logic             sout,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             carry
);

  localparam logic [3:0] OP_HOLD = 4'd0;
  localparam logic [3:0] OP_LOAD = 4'd1;
  localparam logic [3:0] OP_SRS  = 4'd2;
  localparam logic [3:0] OP_SLS  = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_NEG  = 4'd5;
  localparam logic [3:0] OP_INC  = 4'd6;
  localparam logic [3:0] OP_DEC  = 4'd7;
  localparam logic [3:0] OP_ROR  = 4'd8;
  localparam logic [3:0] OP_ROL  = 4'd9;
  localparam logic [3:0] OP_ASR  = 4'd10;
  localparam logic [3:0] OP_LSL  = 4'd11;
  localparam logic [3:0] OP_CLR  = 4'd12;

  logic [3:0]       op_q;
  logic [AMT_W-1:0] cnt;     // steps still to run while busy
  logic [3:0]       cur_op;
  logic             is_step;
  logic [WIDTH-1:0] step_val;
  logic             step_out;
  logic [WIDTH-1:0] sc_val;
  logic             sc_carry;
  logic [WIDTH:0]   inc_ext;

  // While busy the latched op drives the step logic; otherwise the live op.
  assign cur_op  = busy ? op_q : op;
  assign is_step = (op == OP_SRS) || (op == OP_SLS) || (op == OP_ROR) ||
                   (op == OP_ROL) || (op == OP_ASR) || (op == OP_LSL);
  assign inc_ext = {1'b0, pout} + {{WIDTH{1'b0}}, 1'b1};
  assign zero    = (pout == '0);

  always_comb begin
    step_val = pout;
    step_out = 1'b0;
    case (cur_op)
      OP_SRS: begin step_val = {sin, pout[WIDTH-1:1]};          step_out = pout[0];       end
      OP_SLS: begin step_val = {pout[WIDTH-2:0], sin};          step_out = pout[WIDTH-1]; end
      OP_ROR: begin step_val = {pout[0], pout[WIDTH-1:1]};      step_out = pout[0];       end
      OP_ROL: begin step_val = {pout[WIDTH-2:0], pout[WIDTH-1]}; step_out = pout[WIDTH-1]; end
      OP_ASR: begin step_val = {pout[WIDTH-1], pout[WIDTH-1:1]}; step_out = pout[0];       end
      OP_LSL: begin step_val = {pout[WIDTH-2:0], 1'b0};         step_out = pout[WIDTH-1]; end
      default: ;
    endcase
  end

  always_comb begin
    sc_val   = pout;
    sc_carry = 1'b0;
    case (op)
      OP_LOAD: sc_val = pin;
      OP_NOT:  sc_val = ~pout;
      OP_NEG:  begin sc_val = ~pout + {{(WIDTH-1){1'b0}}, 1'b1}; sc_carry = (pout == '0); end
      OP_INC:  begin sc_val = inc_ext[WIDTH-1:0];                sc_carry = inc_ext[WIDTH]; end
      OP_DEC:  begin sc_val = pout - {{(WIDTH-1){1'b0}}, 1'b1}; sc_carry = (pout == '0); end
      OP_CLR:  sc_val = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pout  <= '0;
      sout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      carry <= 1'b0;
      cnt   <= '0;
      op_q  <= OP_HOLD;
    end else begin
      done <= 1'b0;
      if (busy) begin
        pout  <= step_val;
        sout  <= step_out;
        carry <= step_out;
        cnt   <= cnt - {{(AMT_W-1){1'b0}}, 1'b1};
        if (cnt == {{(AMT_W-1){1'b0}}, 1'b1}) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end else if (start) begin
        op_q <= op;
        if (is_step) begin
          // Step 1 lands on the accept edge; a zero count only pulses done.
          if (amt == '0) begin
            done <= 1'b1;
          end else begin
            pout  <= step_val;
            sout  <= step_out;
            carry <= step_out;
            if (amt == {{(AMT_W-1){1'b0}}, 1'b1}) begin
              done <= 1'b1;
            end else begin
              busy <= 1'b1;
              cnt  <= amt - {{(AMT_W-1){1'b0}}, 1'b1};
            end
          end
        end else begin
          pout  <= sc_val;
          carry <= sc_carry;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule
